// File: rtl/cic_pkg.sv
// Shared CIC definitions: stage limits, rounding constant, parameter checks.
// Imported by the comb and integrator sections.
package cic_pkg;

  localparam int CIC_MAX_ORDER = 8;
  localparam int CIC_MAX_DELAY = 2;

  typedef enum logic {
    SCALE_TRUNC = 1'b0,
    SCALE_ROUND = 1'b1
  } scale_e;

  // Half an output LSB expressed in internal LSBs.
  function automatic int unsigned rnd_const(
    input int nin,
    input int nout
  );
    if (nin <= nout) return 0;
    return 32'd1 << (nin - nout - 1);
  endfunction

  function automatic bit order_ok(input int order);
    return (order >= 1) && (order <= CIC_MAX_ORDER);
  endfunction

  function automatic bit delay_ok(input int m);
    return (m >= 1) && (m <= CIC_MAX_DELAY);
  endfunction

  function automatic bit width_ok(
    input int nin,
    input int nout
  );
    return (nout >= 1) && (nout <= nin);
  endfunction

  function automatic bit params_ok(
    input int order,
    input int m,
    input int nin,
    input int nout
  );
    return order_ok(order) && delay_ok(m)
        && width_ok(nin, nout);
  endfunction

endpackage

// File: rtl/cic_comb_n_if.sv
// Sample stream into and out of the CIC comb section.
// master drives din/din_valid, slave returns dout/dout_valid.
interface cic_comb_n_if #(
  parameter int NIN  = 21,
  parameter int NOUT = 17
);

  logic signed [NIN-1:0]  din;
  logic                   din_valid;
  logic signed [NOUT-1:0] dout;
  logic                   dout_valid;

  modport master (
    output din,
    output din_valid,
    input  dout,
    input  dout_valid
  );

  modport slave (
    input  din,
    input  din_valid,
    output dout,
    output dout_valid
  );

endinterface

// File: rtl/cic_comb_stage.sv
// One comb differentiator y = x - x[-M] with an M-deep delay line.
// State only advances on valid input; the valid bit moves every cycle.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int W = 21,
  parameter int M = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         sclr,
  input  logic [W-1:0] x,
  input  logic         xv,
  output logic [W-1:0] y,
  output logic         yv
);

  logic [W-1:0] dl [M];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y  <= '0;
      yv <= 1'b0;
      for (int i = 0; i < M; i++) dl[i] <= '0;
    end else if (sclr) begin
      y  <= '0;
      yv <= 1'b0;
      for (int i = 0; i < M; i++) dl[i] <= '0;
    end else begin
      yv <= xv;
      if (xv) begin
        // modulo-2^W difference, wrap is intended
        y     <= x - dl[M-1];
        dl[0] <= x;
        for (int i = 1; i < M; i++) dl[i] <= dl[i-1];
      end
    end
  end

endmodule

// File: rtl/cic_comb_n.sv
// CIC decimator comb section: ORDER differentiators, truncate/round scaling.
// Define CIC_COMB_WARMUP_EN to suppress the first ORDER*M transient strobes.
module cic_comb_n
  import cic_pkg::*;
#(
  parameter int NIN        = 21,
  parameter int NOUT       = 17,
  parameter int ORDER      = 3,
  parameter int DIFF_DELAY = 1,
  parameter int ROUND      = 0
) (
  input logic        clk,
  input logic        rstn,
  input logic        sclr,
  cic_comb_n_if.slave bus
);

  if (!params_ok(ORDER, DIFF_DELAY, NIN, NOUT)) begin : g_bad
    $error("cic_comb_n: illegal ORDER/DIFF_DELAY/NIN/NOUT");
  end

  localparam scale_e MODE =
    ((ROUND != 0) && (NIN > NOUT)) ? SCALE_ROUND : SCALE_TRUNC;
  localparam logic [NIN-1:0] RND =
    (MODE == SCALE_ROUND) ? NIN'(rnd_const(NIN, NOUT)) : '0;
  localparam int SHIFT = NIN - NOUT;

  logic [NIN-1:0]  s [ORDER+1];
  logic            v [ORDER+1];
  logic [NIN-1:0]  s0_q;
  logic            v0_q;
  logic [NIN-1:0]  rounded;
  logic [NOUT-1:0] scaled;
  logic [NOUT-1:0] dout_q;
  logic            dv_q;
  logic            warm;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0_q <= '0;
      v0_q <= 1'b0;
    end else if (sclr) begin
      s0_q <= '0;
      v0_q <= 1'b0;
    end else begin
      v0_q <= bus.din_valid;
      if (bus.din_valid) s0_q <= bus.din;
    end
  end

  assign s[0] = s0_q;
  assign v[0] = v0_q;

  for (genvar k = 1; k <= ORDER; k++) begin : g_stage
    cic_comb_stage #(
      .W (NIN),
      .M (DIFF_DELAY)
    ) u_stage (
      .clk  (clk),
      .rstn (rstn),
      .sclr (sclr),
      .x    (s[k-1]),
      .xv   (v[k-1]),
      .y    (s[k]),
      .yv   (v[k])
    );
  end

  // rounding add wraps mod 2^NIN, like the rest of the datapath
  assign rounded = s[ORDER] + RND;
  assign scaled  = NOUT'(rounded >> SHIFT);

`ifdef CIC_COMB_WARMUP_EN
  localparam int WARM_N = ORDER * DIFF_DELAY;
  localparam int CW     = $clog2(WARM_N + 1);

  logic [CW-1:0]  cnt;
  logic [ORDER:0] wp;
  logic           full;

  assign full = (cnt == CW'(WARM_N));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      wp  <= '0;
    end else if (sclr) begin
      cnt <= '0;
      wp  <= '0;
    end else begin
      wp <= {wp[ORDER-1:0], bus.din_valid & full};
      if (bus.din_valid && !full) cnt <= cnt + CW'(1);
    end
  end

  assign warm = wp[ORDER];
`else
  assign warm = 1'b1;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_q <= '0;
      dv_q   <= 1'b0;
    end else if (sclr) begin
      dout_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      dv_q <= v[ORDER] & warm;
      if (v[ORDER]) dout_q <= scaled;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;

endmodule

// File: tb/tb_cic_comb_n.sv
// Directed-vector bench for cic_comb_n over five parameter sets.
// Expected sequences are worked out by hand from the comb difference equation.
`timescale 1ns/1ps
module tb_cic_comb_n;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic sclr = 1'b0;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;
  int dc[$];
  int qv0[$], qt0[$], qv1[$], qt1[$], qv2[$], qt2[$];
  int qv3[$], qt3[$], qv4[$], qt4[$];

`ifdef CIC_COMB_WARMUP_EN
  localparam bit WU = 1'b1;
`else
  localparam bit WU = 1'b0;
`endif

  cic_comb_n_if #(.NIN(16), .NOUT(16)) b0 ();
  cic_comb_n_if #(.NIN(8),  .NOUT(8))  b1 ();
  cic_comb_n_if #(.NIN(8),  .NOUT(8))  b2 ();
  cic_comb_n_if #(.NIN(8),  .NOUT(4))  b3 ();
  cic_comb_n_if #(.NIN(8),  .NOUT(4))  b4 ();

  cic_comb_n #(.NIN(16), .NOUT(16), .ORDER(3), .DIFF_DELAY(1), .ROUND(0))
    u0 (.clk(clk), .rstn(rstn), .sclr(sclr), .bus(b0));
  cic_comb_n #(.NIN(8), .NOUT(8), .ORDER(1), .DIFF_DELAY(2), .ROUND(0))
    u1 (.clk(clk), .rstn(rstn), .sclr(sclr), .bus(b1));
  cic_comb_n #(.NIN(8), .NOUT(8), .ORDER(1), .DIFF_DELAY(1), .ROUND(0))
    u2 (.clk(clk), .rstn(rstn), .sclr(sclr), .bus(b2));
  cic_comb_n #(.NIN(8), .NOUT(4), .ORDER(1), .DIFF_DELAY(1), .ROUND(0))
    u3 (.clk(clk), .rstn(rstn), .sclr(sclr), .bus(b3));
  cic_comb_n #(.NIN(8), .NOUT(4), .ORDER(1), .DIFF_DELAY(1), .ROUND(1))
    u4 (.clk(clk), .rstn(rstn), .sclr(sclr), .bus(b4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (b0.dout_valid) begin qv0.push_back(int'(b0.dout)); qt0.push_back(cyc); end
    if (b1.dout_valid) begin qv1.push_back(int'(b1.dout)); qt1.push_back(cyc); end
    if (b2.dout_valid) begin qv2.push_back(int'(b2.dout)); qt2.push_back(cyc); end
    if (b3.dout_valid) begin qv3.push_back(int'(b3.dout)); qt3.push_back(cyc); end
    if (b4.dout_valid) begin qv4.push_back(int'(b4.dout)); qt4.push_back(cyc); end
  end

  task automatic chk(input string tag, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic idle();
    b0.din_valid = 1'b0;
    b1.din_valid = 1'b0;
    b2.din_valid = 1'b0;
    b3.din_valid = 1'b0;
    b4.din_valid = 1'b0;
  endtask

  task automatic drive(input int d, input int val);
    case (d)
      0: begin b0.din = 16'(val); b0.din_valid = 1'b1; end
      1: begin b1.din = 8'(val);  b1.din_valid = 1'b1; end
      2: begin b2.din = 8'(val);  b2.din_valid = 1'b1; end
      3: begin b3.din = 8'(val);  b3.din_valid = 1'b1; end
      default: begin b4.din = 8'(val); b4.din_valid = 1'b1; end
    endcase
  endtask

  task automatic feed(input int d, input int vals[$], input int gap);
    foreach (vals[i]) begin
      @(negedge clk); idle(); drive(d, vals[i]); dc.push_back(cyc);
      repeat (gap) begin @(negedge clk); idle(); end
    end
    @(negedge clk); idle();
  endtask

  task automatic clr();
    @(negedge clk); idle(); sclr = 1'b1;
    @(negedge clk); sclr = 1'b0;
  endtask

  // Compare strobed outputs of DUT d against exp, dropping warm-up outputs.
  task automatic check_seq(input string tag, input int d, input int exp[$],
                           input int lat, input int wu_n);
    int gv[$];
    int gt[$];
    int skip;
    skip = WU ? wu_n : 0;
    repeat (lat + 2) @(negedge clk);
    case (d)
      0: begin gv = qv0; gt = qt0; qv0.delete(); qt0.delete(); end
      1: begin gv = qv1; gt = qt1; qv1.delete(); qt1.delete(); end
      2: begin gv = qv2; gt = qt2; qv2.delete(); qt2.delete(); end
      3: begin gv = qv3; gt = qt3; qv3.delete(); qt3.delete(); end
      default: begin gv = qv4; gt = qt4; qv4.delete(); qt4.delete(); end
    endcase
    chk({tag, "_count"}, gv.size(), exp.size() - skip);
    for (int j = skip; j < exp.size(); j++) begin
      if (j - skip < gv.size()) begin
        chk($sformatf("%s_val%0d", tag, j), gv[j-skip], exp[j]);
        chk($sformatf("%s_lat%0d", tag, j), gt[j-skip] - dc[j], lat);
      end
    end
    dc.delete();
  endtask

  initial begin
    idle();
    b0.din = '0; b1.din = '0; b2.din = '0; b3.din = '0; b4.din = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_dout0", int'(b0.dout), 0); chk("rst_dv0", int'(b0.dout_valid), 0);
    chk("rst_dout1", int'(b1.dout), 0); chk("rst_dv1", int'(b1.dout_valid), 0);
    chk("rst_dout2", int'(b2.dout), 0); chk("rst_dv2", int'(b2.dout_valid), 0);
    chk("rst_dout3", int'(b3.dout), 0); chk("rst_dv3", int'(b3.dout_valid), 0);
    chk("rst_dout4", int'(b4.dout), 0); chk("rst_dv4", int'(b4.dout_valid), 0);

    feed(1, '{0, 1, 2, 3, 4, 5, 6, 7}, 0);
    check_seq("ramp_m2", 1, '{0, 1, 2, 2, 2, 2, 2, 2}, 3, 2);

    feed(2, '{255, 1}, 0);
    check_seq("wrap", 2, '{-1, 2}, 3, 1);

    feed(3, '{0, 24, 151}, 0);
    check_seq("trunc", 3, '{0, 1, 7}, 3, 1);

    feed(4, '{0, 24, 151}, 0);
    check_seq("round", 4, '{0, 2, -8}, 3, 1);

    clr();
    chk("sclr_dout4", int'(b4.dout), 0);
    chk("sclr_dv4", int'(b4.dout_valid), 0);

    feed(0, '{1, 0, 0, 0, 0, 0, 0, 0}, 0);
    check_seq("impulse", 0, '{1, -3, 3, -1, 0, 0, 0, 0}, 5, 3);

    clr();
    feed(0, '{1, 0, 0, 0, 0, 0, 0, 0}, 3);
    check_seq("sparse", 0, '{1, -3, 3, -1, 0, 0, 0, 0}, 5, 3);

    clr();
    @(negedge clk); idle(); drive(0, 1);
    @(negedge clk); idle();
    @(negedge clk); idle(); drive(0, 5); sclr = 1'b1;
    @(negedge clk); idle(); sclr = 1'b0;
    repeat (10) @(negedge clk);
    chk("sclr_flush_count", qv0.size(), 0);
    qv0.delete(); qt0.delete();

    feed(0, '{1, 0, 0, 0, 0, 0}, 0);
    check_seq("post_sclr", 0, '{1, -3, 3, -1, 0, 0}, 5, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
